// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART receive/transmit buffering blocks.
//   UART_DATA_W  : default byte width, matches UART_CONTROLLER data_out
//   rxb_state_t  : capture FSM states of uart_rx_buffer
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        RXB_IDLE,
        RXB_ACK,
        RXB_WAIT_LOW
    } rxb_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock register-array FIFO with a combinational head read.
//   Shared by the RX and TX buffering paths.
//   clk, rst_n   : clock, asynchronous active-low reset (clears storage too)
//   push_i/data_i: write data_i at the edge (ignored when full)
//   pop_i        : advance head at the edge (ignored when empty)
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : entries held, 0..DEPTH
//   head_o       : mem[rd_ptr], oldest entry
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guards live here so the FIFO can never over/underflow whatever the caller does.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);  // power-of-2 depth: wraps naturally
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            // Simultaneous push+pop leaves the count unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer
//   Receive-side byte buffer between UART_CONTROLLER and the OS simulator.
//   Captures each byte the controller flags, acknowledges it with a one-cycle
//   nic_read pulse, and queues it for the OS.
//   clk, rst_n    : clock, asynchronous active-low reset
//   nic_irq       : controller "byte ready" level
//   nic_data      : controller byte, valid while nic_irq=1
//   nic_read      : registered one-cycle acknowledge to the controller
//   os_data       : head-of-queue byte, valid while os_valid=1
//   os_valid      : queue non-empty (OS receive interrupt)
//   os_read       : pop strobe, one byte per high cycle
//   count         : entries held
//   overflow      : sticky, byte discarded while full (DROP_ON_FULL=1 only)
//   clr_overflow  : synchronous clear of overflow (set wins if simultaneous)
// -----------------------------------------------------------------------------
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int DEPTH        = 16,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     nic_irq,
    input  logic [DATA_W-1:0]        nic_data,
    output logic                     nic_read,
    output logic [DATA_W-1:0]        os_data,
    output logic                     os_valid,
    input  logic                     os_read,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    rxb_state_t state_q;
    logic       nic_read_q;
    logic       overflow_q;
    logic       full;
    logic       empty;
    logic       capture;
    logic       drop;

    // A byte is taken only from IDLE, so one irq assertion yields one capture.
    assign capture = (state_q == RXB_IDLE) & nic_irq & ~full;
    assign drop    = DROP_ON_FULL & (state_q == RXB_IDLE) & nic_irq & full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RXB_IDLE;
            nic_read_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            nic_read_q <= 1'b0;
            case (state_q)
                RXB_IDLE: begin
                    // Full with DROP_ON_FULL=0: stay here, byte remains in the controller.
                    if (capture || drop) begin
                        state_q    <= RXB_ACK;
                        nic_read_q <= 1'b1;
                    end
                end
                RXB_ACK:      state_q <= RXB_WAIT_LOW;
                RXB_WAIT_LOW: if (!nic_irq) state_q <= RXB_IDLE;
                default:      state_q <= RXB_IDLE;
            endcase

            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (capture),
        .data_i  (nic_data),
        .pop_i   (os_read),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .head_o  (os_data)
    );

    assign nic_read = nic_read_q;
    assign os_valid = ~empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT A: stall on full
    logic          a_irq, a_read, a_valid, a_os_read, a_ovf, a_clr;
    logic [DW-1:0] a_data, a_os_data;
    logic [CW-1:0] a_count;
    // DUT B: drop on full
    logic          b_irq, b_read, b_valid, b_os_read, b_ovf, b_clr;
    logic [DW-1:0] b_data, b_os_data;
    logic [CW-1:0] b_count;

    uart_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .DROP_ON_FULL(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .nic_irq(a_irq), .nic_data(a_data), .nic_read(a_read),
        .os_data(a_os_data), .os_valid(a_valid), .os_read(a_os_read), .count(a_count),
        .overflow(a_ovf), .clr_overflow(a_clr)
    );

    uart_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .DROP_ON_FULL(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .nic_irq(b_irq), .nic_data(b_data), .nic_read(b_read),
        .os_data(b_os_data), .os_valid(b_valid), .os_read(b_os_read), .count(b_count),
        .overflow(b_ovf), .clr_overflow(b_clr)
    );

    int n_cmp = 0;
    int n_err = 0;
    int a_pulses = 0;
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;
    bit prod_done = 1'b0;
    logic [7:0] exp_q[$];    // bytes in the order the OS must receive them
    logic [7:0] mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the OS side takes a byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_read) a_pulses++;
            if (a_read && a_prev) begin
                n_cmp++; n_err++;
                $display("FAIL a_nic_read_double: got 2 consecutive high cycles expected 1");
            end
            if (b_read && b_prev) begin
                n_cmp++; n_err++;
                $display("FAIL b_nic_read_double: got 2 consecutive high cycles expected 1");
            end
            if (a_valid && a_os_read) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL pop_unexpected: got byte %0h expected no byte", a_os_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pop_data", 32'(a_os_data), 32'(mon_e));
                end
            end
        end
        a_prev = rst_n ? a_read : 1'b0;
        b_prev = rst_n ? b_read : 1'b0;
    end

    // Controller model for DUT A: hold irq until acked, then drop it for a cycle.
    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        a_irq = 1'b1; a_data = b; exp_q.push_back(b);
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (a_read) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL send_ack_timeout: got no nic_read expected ack for %0h", b);
        end
        @(posedge clk); #1;
        a_irq = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic os_pop();
        a_os_read = 1'b1;
        @(posedge clk); #1;
        a_os_read = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        a_irq = 0; a_data = 0; a_os_read = 0; a_clr = 0;
        b_irq = 0; b_data = 0; b_os_read = 0; b_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_count", 32'(a_count), 0);
        chk("rst_a_valid", 32'(a_valid), 0);
        chk("rst_b_ovf",   32'(b_ovf), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: reset while ACK is in progress
        a_irq = 1'b1; a_data = 8'h5A;
        @(posedge clk); #1;
        chk("pre_rst_ack", 32'(a_read), 1);
        rst_n = 1'b0; #1;
        chk("rst_nic_read", 32'(a_read), 0);
        chk("rst_valid",    32'(a_valid), 0);
        chk("rst_count",    32'(a_count), 0);
        chk("rst_os_data",  32'(a_os_data), 0);
        a_irq = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: single byte
        base = a_pulses;
        send_byte(8'hA5);
        chk("single_pulses", 32'(a_pulses - base), 1);
        chk("single_valid",  32'(a_valid), 1);
        chk("single_data",   32'(a_os_data), 32'hA5);
        chk("single_count",  32'(a_count), 1);
        os_pop();
        chk("single_pop_count", 32'(a_count), 0);
        chk("single_pop_valid", 32'(a_valid), 0);

        // 3: fill, partial drain, refill across the pointer wrap
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("fill_count", 32'(a_count), 16);
        for (int i = 0; i < 4; i++) os_pop();
        for (int i = 16; i < 20; i++) send_byte(8'(i));
        chk("wrap_count", 32'(a_count), 16);
        chk("wrap_head",  32'(a_os_data), 32'h04);

        // 4: full stall, released by one pop
        base = a_pulses;
        a_irq = 1'b1; a_data = 8'h77; exp_q.push_back(8'h77);
        repeat (5) begin @(posedge clk); #1; end
        chk("stall_pulses", 32'(a_pulses - base), 0);
        chk("stall_count",  32'(a_count), 16);
        a_os_read = 1'b1;
        @(posedge clk); #1;
        a_os_read = 1'b0;
        chk("stall_pop_count", 32'(a_count), 15);
        chk("stall_pop_noack", 32'(a_read), 0);
        @(posedge clk); #1;
        chk("stall_ack",       32'(a_read), 1);
        chk("stall_cap_count", 32'(a_count), 16);
        a_irq = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_one_pulse", 32'(a_pulses - base), 1);
        for (int i = 0; i < 40 && a_valid; i++) os_pop();
        chk("drain_count", 32'(a_count), 0);
        chk("drain_sb",    32'(exp_q.size()), 0);

        // 6: push and pop on the same edge with one entry held
        send_byte(8'h11);
        chk("sim_pre_count", 32'(a_count), 1);
        a_irq = 1'b1; a_data = 8'h55; exp_q.push_back(8'h55);
        a_os_read = 1'b1;
        @(posedge clk); #1;
        a_os_read = 1'b0;
        chk("sim_count", 32'(a_count), 1);
        chk("sim_data",  32'(a_os_data), 32'h55);
        chk("sim_ack",   32'(a_read), 1);
        a_irq = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        os_pop();
        os_pop();    // read while empty
        chk("empty_read_count", 32'(a_count), 0);
        chk("empty_read_valid", 32'(a_valid), 0);

        // 5: drop-on-full variant
        for (int i = 0; i < 16; i++) begin
            b_irq = 1'b1; b_data = 8'(8'h20 + i);
            @(posedge clk); #1;
            @(posedge clk); #1;
            b_irq = 1'b0;
            @(posedge clk); #1;
        end
        chk("drop_fill_count", 32'(b_count), 16);
        chk("drop_fill_head",  32'(b_os_data), 32'h20);
        chk("drop_fill_ovf",   32'(b_ovf), 0);
        b_irq = 1'b1; b_data = 8'hEE;
        @(posedge clk); #1;
        chk("drop_ack",   32'(b_read), 1);
        chk("drop_ovf",   32'(b_ovf), 1);
        chk("drop_count", 32'(b_count), 16);
        chk("drop_head",  32'(b_os_data), 32'h20);
        @(posedge clk); #1;
        b_irq = 1'b0;
        @(posedge clk); #1;
        chk("drop_sticky", 32'(b_ovf), 1);
        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        chk("drop_clr", 32'(b_ovf), 0);
        b_irq = 1'b1; b_data = 8'hEF; b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        chk("drop_set_priority", 32'(b_ovf), 1);
        @(posedge clk); #1;
        b_irq = 1'b0;
        @(posedge clk); #1;

        // Random traffic on DUT A, ordered delivery checked by the monitor
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    send_byte(8'($urandom_range(0, 255)));
                end
                prod_done = 1'b1;
            end
            begin
                for (int c = 0; c < 20000; c++) begin
                    @(posedge clk); #1;
                    if (prod_done && exp_q.size() == 0) break;
                    if ((c / 400) % 2 == 0) a_os_read = ($urandom_range(0, 7) == 0);
                    else                    a_os_read = ($urandom_range(0, 1) == 0);
                end
                a_os_read = 1'b0;
            end
        join
        chk("rand_drain_sb",  32'(exp_q.size()), 0);
        chk("rand_drain_cnt", 32'(a_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
